// File: rtl/round_robin_resource_scheduler.sv
// Round-robin scheduler granting one shared multi-cycle resource to N requesters.
// A grant is held until done, requester abort, or hold-time watchdog expiry.
module round_robin_resource_scheduler #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr, ptr_next;
  logic [HW-1:0]  hold_cnt, hold_next;
  logic [N-1:0]   grant_next;
  logic [IDW-1:0] id_next;
  logic           busy_next;
  logic           timeout_next;

  logic           found;
  logic [IDW-1:0] win_id;
  logic           rel_done, rel_abort, rel_wd;
  logic [IDW-1:0] ptr_after;

  // Circular priority scan starting at ptr, wrapping explicitly modulo N
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[IDW'(idx)]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  // Release conditions; done has priority over abort and watchdog
  always_comb begin
    rel_done  = done;
    rel_abort = !req[grant_id];
    rel_wd    = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
    ptr_after = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    grant_next   = grant;
    id_next      = grant_id;
    busy_next    = busy;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        grant_next = '0;
        id_next    = '0;
        busy_next  = 1'b0;
        if (found) begin
          state_next = BUSY;
          grant_next = N'(1) << win_id;
          id_next    = win_id;
          busy_next  = 1'b1;
          hold_next  = '0;
        end
      end
      BUSY: begin
        if (rel_done || rel_abort || rel_wd) begin
          state_next   = IDLE;
          grant_next   = '0;
          id_next      = '0;
          busy_next    = 1'b0;
          ptr_next     = ptr_after;
          timeout_next = rel_wd && !rel_done && !rel_abort;
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
      grant    <= grant_next;
      grant_id <= id_next;
      busy     <= busy_next;
      timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_round_robin_resource_scheduler.sv
// Directed bench for round_robin_resource_scheduler (N=4, MAX_HOLD=4).
module tb_round_robin_resource_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  round_robin_resource_scheduler #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       to;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic eto);
    checks++;
    if (grant !== eg || grant_id !== eid || busy !== eb || timeout !== eto) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
               name, grant, grant_id, busy, timeout, eg, eid, eb, eto);
    end
  endtask

  initial begin
    // Reset held with all requests high
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    // Rotation with done two cycles into each grant
    vecs[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    // Skip and wrap: grant 2 moves ptr to 3, then 0011 wraps to 0 then 1
    vecs[15] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    // Abort by requester 1; ptr=2 seen as next winner under 1111
    vecs[20] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    // Watchdog: 4 grant cycles then timeout pulse
    vecs[22] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1};
    // Watchdog cycle coinciding with done: no timeout
    vecs[26] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[27] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[28] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[29] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[30] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    // done while idle is ignored
    vecs[31] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[32] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #3;
    check("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      done  = vecs[i].done;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].b, vecs[i].to);
    end

    // Async reset mid-BUSY with requester 3 granted (ptr is 3 here)
    req  = 4'b1000;
    done = 1'b0;
    @(posedge clk);
    #1;
    check("grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midbusy_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_resource_scheduler.md
# round_robin_resource_scheduler

Registered N-requester round-robin scheduler that shares one multi-cycle resource (a bus port, memory bank or shared ALU) between requesters. A winner keeps its grant for the whole transaction until the resource signals `done`, the winner drops its request, or a hold-time watchdog expires. Priority then rotates past the last winner. The block sits between the requesters and the resource's mux select and enable.

## Interface
- `N`, default 4: number of requesters, legal range 2..16.
- `MAX_HOLD`, default 16: maximum number of consecutive cycles a single grant may be held. 0 disables the watchdog.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req`  input  N  request per requester; level-sensitive, held high for the whole transaction.
- `done`  input  1  resource completion strobe; only meaningful while `busy`=1.
- `grant`  output  N  registered one-hot grant, all-zero when idle.
- `grant_id`  output  $clog2(N)  index of the current winner; 0 when idle.
- `busy`  output  1  high while any grant is held (equals OR of `grant`).
- `timeout`  output  1  one-cycle pulse when the watchdog forcibly revokes a grant.

## Operation
- The FSM has two states, IDLE and BUSY. There is also a priority pointer `ptr` (width $clog2(N)) and a hold counter `hold_cnt` (width $clog2(MAX_HOLD+1)).
- **Reset (`rst_n`=0, asynchronous):**
  - State goes to IDLE; `ptr`=0; `hold_cnt`=0.
  - `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0 immediately, without waiting for a clock.
- **IDLE:**
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr+1`, …, N-1, 0, …, `ptr-1` (modulo N).
  - Register that bit's one-hot in `grant` and its index in `grant_id`, go to BUSY, and clear `hold_cnt`.
  - If `req`=0, stay in IDLE with all outputs 0.
- **BUSY:** the grant stays frozen. A grant ends on any of three release conditions:
  - (a) `done`=1.
  - (b) `req[grant_id]`=0, meaning the requester aborted.
  - (c) `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`-1 with neither (a) nor (b).
- **On release:**
  - The next state is IDLE, `grant` becomes 0, and `ptr` = (`grant_id`+1) mod N.
  - On (c) only, `timeout`=1 for exactly that one cycle.
  - Otherwise, while in BUSY, `hold_cnt` increments and saturates at `MAX_HOLD`.
- **Simultaneous conditions:**
  - `done` together with a request drop is treated as (a).
  - `done` on the watchdog cycle is treated as (a), so no `timeout` pulse.
- Requests from other requesters during BUSY are ignored. They are not latched and must stay asserted to be considered.
- `done` while in IDLE is ignored.
- `ptr` changes only on release. When N is not a power of two, the wrap is explicit modulo N.

## Timing
- **Grant latency:** a request sampled at edge t in IDLE gives `grant` high from t+1.
- **Release latency:** a release condition sampled at edge t gives `grant`=0 from t+1.
  - The next arbitration samples `req` at t+1, so the next grant appears at t+2.
  - There is exactly one idle bubble cycle between back-to-back grants.
- **Watchdog:** a grant never stays high for more than `MAX_HOLD` cycles. `timeout` is high in the first cycle after the grant drops.
- All outputs are driven directly from flops; there are no combinational paths from `req` or `done` to the outputs.
- Reset asserted mid-transaction drops `grant` asynchronously. After `rst_n` deasserts, arbitration restarts from `ptr`=0.

## Test plan
- **Reset:** with N=4, hold `req`=4'b1111 while `rst_n`=0 → `grant`=0 and `busy`=0.
  - On release of reset, the first grant is 4'b0001 one cycle later.
- **Rotation:** `req`=4'b1111 constantly, `done` pulsed 2 cycles after each grant → grants 0001, 0010, 0100, 1000, 0001, with one zero cycle between each.
- **Skip and wrap:** `ptr`=3 (after a grant to requester 2), `req`=4'b0011 → the grant goes to requester 0; the next grant after `done` goes to requester 1.
- **Abort:** requester 1 is granted, `req[1]` drops with `done`=0 → `grant`=0 next cycle, `timeout`=0, `ptr`=2.
- **Watchdog:** `MAX_HOLD`=4, requester 2 granted, `done` never asserted → `grant` stays 0100 for exactly 4 cycles, then goes 0 with `timeout`=1 for one cycle.
  - Repeat with `done`=1 on the 4th cycle → no `timeout` pulse.
- **Async reset mid-BUSY:** `rst_n` falls between edges while requester 3 is granted → `grant` goes 0 before the next edge.
  - After release of reset with `req`=4'b1010, requester 1 wins.
